// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared types and width defaults for the Fibonacci request scheduler
package fib_pkg;

  localparam int FIB_IN_W  = 6;
  localparam int FIB_OUT_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } sched_state_t;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fib_req_fifo.sv
// rtl/fib_req_fifo.sv - synchronous request FIFO with combinational head output
module fib_req_fifo
  import fib_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = FIB_IN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Full/empty are taken from the registered count only; no same-cycle look-ahead.
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/fib_req_sched.sv
// rtl/fib_req_sched.sv - queues Fibonacci requests, drives the engine one at a time,
// and returns tagged responses with a watchdog for hung engine runs
module fib_req_sched
  import fib_pkg::*;
#(
  parameter int INPUT_WIDTH    = FIB_IN_W,
  parameter int OUTPUT_WIDTH   = FIB_OUT_W,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [INPUT_WIDTH-1:0]  req_n,
  output logic                    go,
  output logic [INPUT_WIDTH-1:0]  n,
  input  logic                    done,
  input  logic [OUTPUT_WIDTH-1:0] result,
  input  logic                    overflow,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [INPUT_WIDTH-1:0]  rsp_n,
  output logic [OUTPUT_WIDTH-1:0] rsp_result,
  output logic                    rsp_overflow,
  output logic                    rsp_timeout,
  output logic                    busy
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);

  sched_state_t            state_q, state_d;
  logic [INPUT_WIDTH-1:0]  n_q, n_d;
  logic [TO_W-1:0]         wd_cnt_q, wd_cnt_d;
  logic [INPUT_WIDTH-1:0]  rsp_n_q, rsp_n_d;
  logic [OUTPUT_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic                    rsp_overflow_q, rsp_overflow_d;
  logic                    rsp_timeout_q, rsp_timeout_d;

  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [INPUT_WIDTH-1:0]  fifo_head;

  fib_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INPUT_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid),
    .pop   (fifo_pop),
    .din   (req_n),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign req_ready    = !fifo_full;
  assign go           = (state_q == ISSUE);
  assign n            = n_q;
  assign rsp_valid    = (state_q == HOLD);
  assign rsp_n        = rsp_n_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_timeout  = rsp_timeout_q;
  assign busy         = (state_q != IDLE) || !fifo_empty;

  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    wd_cnt_d       = wd_cnt_q;
    rsp_n_d        = rsp_n_q;
    rsp_result_d   = rsp_result_q;
    rsp_overflow_d = rsp_overflow_q;
    rsp_timeout_d  = rsp_timeout_q;
    fifo_pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          n_d      = fifo_head;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        wd_cnt_d = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        // A done arriving on the final watchdog cycle still counts as a real answer.
        if (done) begin
          rsp_n_d        = n_q;
          rsp_result_d   = result;
          rsp_overflow_d = overflow;
          rsp_timeout_d  = 1'b0;
          state_d        = HOLD;
        end else if (wd_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_n_d        = n_q;
          rsp_result_d   = '0;
          rsp_overflow_d = 1'b0;
          rsp_timeout_d  = 1'b1;
          state_d        = HOLD;
        end else begin
          wd_cnt_d = wd_cnt_q + TO_W'(1);
        end
      end
      HOLD: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      n_q            <= '0;
      wd_cnt_q       <= '0;
      rsp_n_q        <= '0;
      rsp_result_q   <= '0;
      rsp_overflow_q <= 1'b0;
      rsp_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      wd_cnt_q       <= wd_cnt_d;
      rsp_n_q        <= rsp_n_d;
      rsp_result_q   <= rsp_result_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_timeout_q  <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_fib_req_sched.sv
// tb/tb_fib_req_sched.sv - scoreboard bench for fib_req_sched with a behavioural engine
module tb_fib_req_sched;

  localparam int IW = 6;
  localparam int OW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [IW-1:0] req_n;
  logic          go;
  logic [IW-1:0] n;
  logic          done;
  logic [OW-1:0] result;
  logic          overflow;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [IW-1:0] rsp_n;
  logic [OW-1:0] rsp_result;
  logic          rsp_overflow;
  logic          rsp_timeout;
  logic          busy;

  fib_req_sched #(
    .INPUT_WIDTH    (IW),
    .OUTPUT_WIDTH   (OW),
    .DEPTH          (4),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_n        (req_n),
    .go           (go),
    .n            (n),
    .done         (done),
    .result       (result),
    .overflow     (overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_n        (rsp_n),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow),
    .rsp_timeout  (rsp_timeout),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] n;
    logic [OW-1:0] res;
    logic          ovf;
    logic          to;
  } rsp_t;

  rsp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   go_cnt   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint unsigned fib(input int k);
    longint unsigned a = 0;
    longint unsigned b = 1;
    longint unsigned t;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Engine model: latency 0 means it never answers.
  int            eng_lat = 12;
  int            eng_cnt = 0;
  logic          eng_busy = 1'b0;
  logic [IW-1:0] eng_n = '0;
  logic          eng_done = 1'b0;
  logic [OW-1:0] eng_result = '0;
  logic          eng_ovf = 1'b0;
  logic          inj_done = 1'b0;
  logic [OW-1:0] inj_result = 32'hDEAD_BEEF;

  assign done     = eng_done | inj_done;
  assign result   = inj_done ? inj_result : eng_result;
  assign overflow = inj_done ? 1'b1 : eng_ovf;

  always @(negedge clk) begin
    longint unsigned f;
    eng_done = 1'b0;
    if (rst) begin
      eng_busy = 1'b0;
    end else if (go && eng_lat != 0) begin
      eng_busy = 1'b1;
      eng_cnt  = eng_lat;
      eng_n    = n;
    end else if (eng_busy) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        f          = fib(int'(eng_n));
        eng_done   = 1'b1;
        eng_result = f[OW-1:0];
        eng_ovf    = (f > 64'h0000_0000_FFFF_FFFF);
        eng_busy   = 1'b0;
      end
    end
  end

  // Response monitor: pops on handshake, checks hold stability and go behaviour.
  logic          held = 1'b0;
  rsp_t          held_rsp;
  logic          prev_go = 1'b0;

  always @(negedge clk) begin
    rsp_t e;
    if (go) begin
      go_cnt++;
      check("go_single_cycle", prev_go, 1'b0);
      if (sb.size() == 0) check("go_unexpected", 1'b1, 1'b0);
      else                check("go_n", n, sb[0].n);
    end
    prev_go = go;
    if (rsp_valid && held) begin
      check("hold_n",   rsp_n,        held_rsp.n);
      check("hold_res", rsp_result,   held_rsp.res);
      check("hold_ovf", rsp_overflow, held_rsp.ovf);
      check("hold_to",  rsp_timeout,  held_rsp.to);
    end
    if (rsp_valid && !rsp_ready) begin
      held         = 1'b1;
      held_rsp.n   = rsp_n;
      held_rsp.res = rsp_result;
      held_rsp.ovf = rsp_overflow;
      held_rsp.to  = rsp_timeout;
    end else begin
      held = 1'b0;
    end
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        check("rsp_n",        rsp_n,        e.n);
        check("rsp_result",   rsp_result,   e.res);
        check("rsp_overflow", rsp_overflow, e.ovf);
        check("rsp_timeout",  rsp_timeout,  e.to);
      end
    end
  end

  function automatic rsp_t expect_for(input logic [IW-1:0] k);
    rsp_t r;
    longint unsigned f = fib(int'(k));
    r.n = k;
    if (eng_lat == 0 || eng_lat > TO) begin
      r.res = '0;
      r.ovf = 1'b0;
      r.to  = 1'b1;
    end else begin
      r.res = f[OW-1:0];
      r.ovf = (f > 64'h0000_0000_FFFF_FFFF);
      r.to  = 1'b0;
    end
    return r;
  endfunction

  task automatic push(input logic [IW-1:0] k);
    req_n     = k;
    req_valid = 1'b1;
    @(negedge clk);
    if (req_ready) sb.push_back(expect_for(k));
    check("push_ready", req_ready, 1'b1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
    #1 check("drain_left", sb.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"},    req_ready,    1'b1);
    check({tag, "_go"},           go,           1'b0);
    check({tag, "_n"},            n,            '0);
    check({tag, "_rsp_valid"},    rsp_valid,    1'b0);
    check({tag, "_rsp_n"},        rsp_n,        '0);
    check({tag, "_rsp_result"},   rsp_result,   '0);
    check({tag, "_rsp_overflow"}, rsp_overflow, 1'b0);
    check({tag, "_rsp_timeout"},  rsp_timeout,  1'b0);
    check({tag, "_busy"},         busy,         1'b0);
  endtask

  initial begin
    int   accepted;
    logic ready6;
    int   go_at_rst;
    int   waited;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_n     = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");

    // Single request: 2 cycles from push to go, response the edge done is sampled.
    @(posedge clk); #1;
    eng_lat = 12;
    push(6'd10);
    @(negedge clk);
    check("t1_go_e0", go, 1'b0);
    check("t1_busy", busy, 1'b1);
    @(negedge clk);
    check("t1_go_e1", go, 1'b1);
    check("t1_n", n, 10);
    waited = 0;
    @(posedge clk);
    while (!done && waited < 40) begin
      @(posedge clk);
      waited++;
    end
    check("t1_done_seen", done, 1'b1);
    @(negedge clk);
    check("t1_rsp_valid", rsp_valid, 1'b1);
    drain(10);
    check("t1_go_count", go_cnt, 1);

    // Overflow boundary, responses in order.
    push(6'd47);
    push(6'd48);
    drain(80);

    // Fill while stalled, then drain in order.
    rsp_ready = 1'b0;
    eng_lat   = 1;
    accepted  = 0;
    ready6    = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_n = IW'(30 + i);
      @(negedge clk);
      if (i == 5) ready6 = req_ready;
      if (req_ready) begin
        sb.push_back(expect_for(IW'(30 + i)));
        accepted++;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    check("t3_accepted", accepted, 5);
    check("t3_ready6", ready6, 1'b0);
    repeat (5) @(posedge clk);
    #1 rsp_ready = 1'b1;
    drain(80);

    // Hung engine: timeout exactly TO cycles after WAIT entry.
    eng_lat = 0;
    push(6'd5);
    repeat (17) @(posedge clk);
    @(negedge clk);
    check("t4_valid_before", rsp_valid, 1'b0);
    @(negedge clk);
    check("t4_valid_at", rsp_valid, 1'b1);
    check("t4_timeout", rsp_timeout, 1'b1);
    drain(10);

    // Late done after timeout is ignored; next request is normal.
    eng_lat = 17;
    push(6'd7);
    drain(40);
    eng_lat = 3;
    push(6'd8);
    drain(40);

    // Done on the final watchdog cycle wins.
    eng_lat = 16;
    push(6'd12);
    drain(40);

    // Stray done during ISSUE and HOLD.
    eng_lat   = 4;
    rsp_ready = 1'b0;
    push(6'd9);
    @(posedge clk); #1 inj_done = 1'b1;
    @(posedge clk); #1 inj_done = 1'b0;
    waited = 0;
    while (!rsp_valid && waited < 30) begin
      @(posedge clk); #1;
      waited++;
    end
    check("t6_rsp_valid", rsp_valid, 1'b1);
    inj_done = 1'b1;
    repeat (2) @(posedge clk);
    #1 inj_done = 1'b0;
    @(negedge clk);
    check("t6_still_valid", rsp_valid, 1'b1);
    @(posedge clk); #1 rsp_ready = 1'b1;
    drain(10);

    // Reset mid-WAIT with three queued requests.
    eng_lat = 0;
    push(6'd1);
    push(6'd2);
    push(6'd3);
    push(6'd4);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    go_at_rst = go_cnt;
    @(negedge clk);
    check_reset_vals("midrst");
    repeat (20) @(posedge clk);
    #1 check("t7_no_go", go_cnt, go_at_rst);
    check("t7_busy", busy, 1'b0);

    eng_lat = 3;
    push(6'd20);
    drain(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
